// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver states and baud-rate derivation.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_e;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int calc_half_bit(input int clk_freq, input int baud_rate);
    return calc_clks_per_bit(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX front end: 2-FF synchronizer, baud counter and one-cycle bit-decision strobe.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around mid-bit, decided one cycle later.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 217,
  parameter int HALF_BIT     = 108
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_rx,
  input  logic clr,
  input  logic half,
  output logic rx_s,
  output logic stb,
  output logic bit_val
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HMID = CW'(HALF_BIT - 1);

  logic          rx_m;
  logic [CW-1:0] cnt;
  logic [CW-1:0] mid;

  // Start bit is decided at half a bit, all later bits one full bit apart.
  assign mid = half ? HMID : LAST;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || clr)   cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] HMID_M1 = CW'(HALF_BIT - 2);
  localparam logic [CW-1:0] LAST_M1 = CW'(CLKS_PER_BIT - 2);

  logic s0, s1, pend;

  // Third vote is the live rx_s in the cycle after mid (count wraps to 0 for full bits).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (cnt == (half ? HMID_M1 : LAST_M1)) s0 <= rx_s;
      if (cnt == mid)                        s1 <= rx_s;
      pend <= (cnt == mid) && !clr;
    end
  end

  assign stb     = pend;
  assign bit_val = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
`else
  assign stb     = (cnt == mid);
  assign bit_val = rx_s;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2 stop bits,
// parity/framing/break reporting and a valid/ready output register with overrun pulse.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun
);
  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = calc_half_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_e            state, state_n;
  logic                 armed;
  logic [3:0]           bcnt, bcnt_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic                 par_q, par_n;
  logic                 ferr_q, ferr_n;
  logic                 one_q, one_n;
  logic                 clr, done, brk_hit, perr;
  logic                 rx_s, stb, bit_val;

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .HALF_BIT    (HALF_BIT)
  ) u_sampler (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_rx   (i_rx),
    .clr    (clr),
    .half   (state == S_START),
    .rx_s   (rx_s),
    .stb    (stb),
    .bit_val(bit_val)
  );

  always_comb begin
    perr = 1'b0;
    if (PARITY == PARITY_EVEN)     perr = ^shreg ^ par_q;
    else if (PARITY == PARITY_ODD) perr = ~(^shreg ^ par_q);
  end

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    sh_n    = shreg;
    par_n   = par_q;
    ferr_n  = ferr_q;
    one_n   = one_q;
    clr     = 1'b0;
    done    = 1'b0;
    brk_hit = 1'b0;
    case (state)
      S_IDLE: if (armed && !rx_s) begin
        clr     = 1'b1;
        state_n = S_START;
      end
      S_START: if (stb) begin
        if (!bit_val) begin
          clr     = 1'b1;
          state_n = S_DATA;
          bcnt_n  = '0;
          par_n   = 1'b0;
          ferr_n  = 1'b0;
          one_n   = 1'b0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_DATA: if (stb) begin
        sh_n = {bit_val, shreg[DATA_BITS-1:1]};
        if (bcnt == LAST_DATA) begin
          bcnt_n  = '0;
          state_n = (PARITY == PARITY_NONE) ? S_STOP : S_PARITY;
        end else begin
          bcnt_n = bcnt + 4'd1;
        end
      end
      S_PARITY: if (stb) begin
        par_n   = bit_val;
        state_n = S_STOP;
      end
      S_STOP: if (stb) begin
        ferr_n = ferr_q | ~bit_val;
        one_n  = one_q | bit_val;
        if (bcnt == LAST_STOP) begin
          // A line held low through the whole frame is a break, not a word.
          if (shreg == '0 && !par_q && !one_n) begin
            brk_hit = 1'b1;
            state_n = S_BREAK;
          end else begin
            done    = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          bcnt_n = bcnt + 4'd1;
        end
      end
      S_BREAK: if (rx_s) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      armed        <= 1'b0;
      bcnt         <= '0;
      shreg        <= '0;
      par_q        <= 1'b0;
      ferr_q       <= 1'b0;
      one_q        <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      armed     <= armed | rx_s;
      bcnt      <= bcnt_n;
      shreg     <= sh_n;
      par_q     <= par_n;
      ferr_q    <= ferr_n;
      one_q     <= one_n;
      o_break   <= brk_hit;
      o_overrun <= done & o_valid & ~i_ready;
      // A held, unaccepted word wins over a newly completed frame.
      if (done && (!o_valid || i_ready)) begin
        o_data       <= shreg;
        o_parity_err <= perr;
        o_frame_err  <= ferr_n;
        o_valid      <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
